// File: rtl/dict_loader.sv
// Boot-time dictionary loader: streams the three field dictionaries from instruction
// memory into the cache controller, holding the controller and processor in reset until finished.
module dict_loader #(
    parameter int          FIELD1_VAL_WIDTH = 7,
    parameter int          FIELD2_VAL_WIDTH = 10,
    parameter int          FIELD3_VAL_WIDTH = 15,
    parameter int          FIELD1_KEY_WIDTH = 3,
    parameter int          FIELD2_KEY_WIDTH = 5,
    parameter int          FIELD3_KEY_WIDTH = 8,
    parameter logic [31:0] DICT_BASE        = 32'h000F_0000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    output logic                        mem_valid,
    input  logic                        mem_ready,
    output logic [31:0]                 mem_addr,
    input  logic [31:0]                 mem_rdata,
    output logic                        dict1_write_enable,
    output logic [FIELD1_VAL_WIDTH-1:0] dict1_write_val,
    output logic                        dict2_write_enable,
    output logic [FIELD2_VAL_WIDTH-1:0] dict2_write_val,
    output logic                        dict3_write_enable,
    output logic [FIELD3_VAL_WIDTH-1:0] dict3_write_val,
    output logic                        proc_resetn,
    output logic                        done,
    output logic                        dict_err
);

    localparam int N1    = 2 ** FIELD1_KEY_WIDTH;
    localparam int N2    = 2 ** FIELD2_KEY_WIDTH;
    localparam int N3    = 2 ** FIELD3_KEY_WIDTH;
    localparam int TOTAL = N1 + N2 + N3;
    localparam int IDX_W = $clog2(TOTAL);

    localparam logic [IDX_W-1:0] DICT2_FIRST = IDX_W'(N1);
    localparam logic [IDX_W-1:0] DICT3_FIRST = IDX_W'(N1 + N2);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;
    typedef enum logic [1:0] {SEL_D1, SEL_D2, SEL_D3} sel_t;

    state_t           state_r;
    logic [IDX_W-1:0] idx_r;
    sel_t             sel_s;
    logic             field_err_s;
    logic [IDX_W-1:0] idx_next_s;
    logic [31:0]      addr_next_s;

    // True when the fetched word carries set bits above the entry's field width.
    function automatic logic high_bits_set(input logic [31:0] word, input int width);
        logic [31:0] keep;
        if (width >= 32) begin
            keep = 32'hFFFF_FFFF;
        end else begin
            keep = (32'h1 << width) - 32'h1;
        end
        return |(word & ~keep);
    endfunction

    // Decode the target dictionary from the global index and check the fetched word.
    always_comb begin
        sel_s       = SEL_D3;
        field_err_s = 1'b0;
        idx_next_s  = idx_r + IDX_W'(1);
        addr_next_s = DICT_BASE + (32'(idx_next_s) << 2);
        if (idx_r < DICT2_FIRST) begin
            sel_s = SEL_D1;
        end else if (idx_r < DICT3_FIRST) begin
            sel_s = SEL_D2;
        end else begin
            sel_s = SEL_D3;
        end
        case (sel_s)
            SEL_D1:  field_err_s = high_bits_set(mem_rdata, FIELD1_VAL_WIDTH);
            SEL_D2:  field_err_s = high_bits_set(mem_rdata, FIELD2_VAL_WIDTH);
            SEL_D3:  field_err_s = high_bits_set(mem_rdata, FIELD3_VAL_WIDTH);
            default: field_err_s = 1'b0;
        endcase
    end

    // Load sequencer; all outputs are registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r            <= IDLE;
            idx_r              <= '0;
            mem_valid          <= 1'b0;
            mem_addr           <= DICT_BASE;
            dict1_write_enable <= 1'b0;
            dict1_write_val    <= '0;
            dict2_write_enable <= 1'b0;
            dict2_write_val    <= '0;
            dict3_write_enable <= 1'b0;
            dict3_write_val    <= '0;
            proc_resetn        <= 1'b0;
            done               <= 1'b0;
            dict_err           <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r   <= FETCH;
                        mem_valid <= 1'b1;
                    end
                end
                FETCH: begin
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        state_r   <= WRITE;
                        dict_err  <= dict_err | field_err_s;
                        case (sel_s)
                            SEL_D1: begin
                                dict1_write_val    <= mem_rdata[FIELD1_VAL_WIDTH-1:0];
                                dict1_write_enable <= 1'b1;
                            end
                            SEL_D2: begin
                                dict2_write_val    <= mem_rdata[FIELD2_VAL_WIDTH-1:0];
                                dict2_write_enable <= 1'b1;
                            end
                            default: begin
                                dict3_write_val    <= mem_rdata[FIELD3_VAL_WIDTH-1:0];
                                dict3_write_enable <= 1'b1;
                            end
                        endcase
                    end
                end
                WRITE: begin
                    dict1_write_enable <= 1'b0;
                    dict2_write_enable <= 1'b0;
                    dict3_write_enable <= 1'b0;
                    if (idx_r == LAST_IDX) begin
                        state_r     <= DONE;
                        done        <= 1'b1;
                        proc_resetn <= 1'b1;
                    end else begin
                        idx_r     <= idx_next_s;
                        mem_addr  <= addr_next_s;
                        mem_valid <= 1'b1;
                        state_r   <= FETCH;
                    end
                end
                DONE: begin
                    state_r <= DONE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dict_loader.sv
// Self-checking bench for dict_loader: random dictionary images against a reference
// model of the image layout, plus stall, error, reset and DONE-state scenarios.
module tb_dict_loader;

    localparam int          W1    = 7;
    localparam int          W2    = 10;
    localparam int          W3    = 15;
    localparam int          N1    = 8;
    localparam int          N2    = 32;
    localparam int          N3    = 256;
    localparam int          TOTAL = N1 + N2 + N3;
    localparam logic [31:0] BASE  = 32'h000F_0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          mem_ready = 1'b1;
    logic          mem_valid;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_rdata;
    logic          dict1_write_enable, dict2_write_enable, dict3_write_enable;
    logic [W1-1:0] dict1_write_val;
    logic [W2-1:0] dict2_write_val;
    logic [W3-1:0] dict3_write_val;
    logic          proc_resetn, done, dict_err;

    dict_loader dut (
        .clk(clk), .reset(reset), .start(start),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .dict1_write_enable(dict1_write_enable), .dict1_write_val(dict1_write_val),
        .dict2_write_enable(dict2_write_enable), .dict2_write_val(dict2_write_val),
        .dict3_write_enable(dict3_write_enable), .dict3_write_val(dict3_write_val),
        .proc_resetn(proc_resetn), .done(done), .dict_err(dict_err)
    );

    always #5 clk = ~clk;

    logic [31:0] image [TOTAL];
    int total = 0;
    int bad   = 0;

    // Reference layout: which dictionary a global index belongs to, and its field mask.
    function automatic int dict_of(input int g);
        if (g < N1) return 1;
        if (g < N1 + N2) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] width_mask(input int d);
        case (d)
            1:       return (32'h1 << W1) - 32'h1;
            2:       return (32'h1 << W2) - 32'h1;
            default: return (32'h1 << W3) - 32'h1;
        endcase
    endfunction

    // Instruction memory holding the image.
    always_comb begin
        mem_rdata = 32'hDEAD_BEEF;
        if (mem_addr >= BASE && mem_addr < BASE + 32'(TOTAL * 4) && mem_addr[1:0] == 2'b00)
            mem_rdata = image[int'((mem_addr - BASE) >> 2)];
    end

    // Strobe/request monitor.
    int          obs_d[$];
    logic [31:0] obs_v[$];
    logic [31:0] req_a[$];
    int          multi_en = 0, en_valid = 0, spurious = 0, valid_cyc = 0;
    logic        prev_valid = 1'b0;
    logic [W1-1:0] p1 = '0;
    logic [W2-1:0] p2 = '0;
    logic [W3-1:0] p3 = '0;

    always @(negedge clk) begin
        int n;
        if (!reset) begin
            n = int'(dict1_write_enable) + int'(dict2_write_enable) + int'(dict3_write_enable);
            if (n > 1) multi_en++;
            if (n > 0 && mem_valid) en_valid++;
            if (dict1_write_enable) begin obs_d.push_back(1); obs_v.push_back(32'(dict1_write_val)); end
            if (dict2_write_enable) begin obs_d.push_back(2); obs_v.push_back(32'(dict2_write_val)); end
            if (dict3_write_enable) begin obs_d.push_back(3); obs_v.push_back(32'(dict3_write_val)); end
            if (dict1_write_val != p1 && !dict1_write_enable) spurious++;
            if (dict2_write_val != p2 && !dict2_write_enable) spurious++;
            if (dict3_write_val != p3 && !dict3_write_enable) spurious++;
            if (mem_valid) valid_cyc++;
            if (mem_valid && !prev_valid) req_a.push_back(mem_addr);
        end
        prev_valid = reset ? 1'b0 : mem_valid;
        p1 = dict1_write_val;
        p2 = dict2_write_val;
        p3 = dict3_write_val;
    end

    task automatic fill_image();
        for (int g = 0; g < TOTAL; g++) image[g] = $urandom() & width_mask(dict_of(g));
    endtask

    task automatic pulse_reset();
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
    endtask

    // Pulse start and run to done; optionally stall the request at index stall_g by 3 cycles.
    task automatic run_load(input int stall_g, output int cyc, output bit timeout,
                            output int stall_cyc, output int early_rel);
        logic [31:0] tgt;
        bit pending;
        int left;
        tgt = BASE + 32'(stall_g) * 32'd4;
        pending = (stall_g >= 0);
        left = 0; cyc = 0; stall_cyc = 0; early_rel = 0;
        @(negedge clk); start = 1'b1;
        while (cyc < 2000) begin
            @(negedge clk); cyc++;
            if (cyc == 1) start = 1'b0;
            if (done) break;
            if (proc_resetn) early_rel++;
            if (stall_g >= 0 && mem_valid && mem_addr == tgt) stall_cyc++;
            if (pending && mem_valid && mem_addr == tgt) begin
                mem_ready = 1'b0; left = 3; pending = 1'b0;
            end else if (left > 0) begin
                left--;
                if (left == 0) mem_ready = 1'b1;
            end
        end
        timeout = !done;
        start = 1'b0;
        mem_ready = 1'b1;
        #1;
    endtask

    // Compare observed strobes from position base against the image model.
    task automatic scan_stream(input int base, output int nbad, output int c1,
                               output int c2, output int c3);
        int nobs, d;
        nobs = obs_d.size() - base;
        nbad = 0; c1 = 0; c2 = 0; c3 = 0;
        for (int i = 0; i < nobs; i++) begin
            d = obs_d[base + i];
            if (d == 1) c1++; else if (d == 2) c2++; else c3++;
            if (i >= TOTAL) nbad++;
            else if (d != dict_of(i) || obs_v[base + i] != (image[i] & width_mask(dict_of(i)))) nbad++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; mem_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0h want 0", mem_valid); end
        total++; if (mem_addr !== BASE) begin bad++; $display("FAIL rst_addr: got %0h want %0h", mem_addr, BASE); end
        total++; if ({dict1_write_enable, dict2_write_enable, dict3_write_enable} !== 3'b000) begin
            bad++; $display("FAIL rst_en: got %0b want 000", {dict1_write_enable, dict2_write_enable, dict3_write_enable}); end
        total++; if ({dict1_write_val, dict2_write_val, dict3_write_val} !== 32'h0) begin
            bad++; $display("FAIL rst_vals: got %0h want 0", {dict1_write_val, dict2_write_val, dict3_write_val}); end
        total++; if ({proc_resetn, done, dict_err} !== 3'b000) begin
            bad++; $display("FAIL rst_status: got %0b want 000", {proc_resetn, done, dict_err}); end
        @(negedge clk); reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        total++; if (mem_valid !== 1'b0) begin bad++; $display("FAIL idle_no_start: got %0h want 0", mem_valid); end
    endtask

    task automatic test_zero_wait();
        int cyc, sc, er, base, rb, me0, sp0, nbad, c1, c2, c3, vc0, ob0;
        bit to;
        logic [31:0] vals0;
        fill_image();
        base = obs_d.size(); rb = req_a.size(); me0 = multi_en; sp0 = spurious;
        run_load(-1, cyc, to, sc, er);
        total++; if (to) begin bad++; $display("FAIL zw_timeout: got done=%0b want 1", done); end
        total++; if (cyc != 593) begin bad++; $display("FAIL zw_done_cycle: got %0d want 593", cyc); end
        total++; if (proc_resetn !== 1'b1 || er != 0) begin
            bad++; $display("FAIL zw_proc_resetn: got %0b early=%0d want 1 early=0", proc_resetn, er); end
        scan_stream(base, nbad, c1, c2, c3);
        total++; if (nbad != 0) begin bad++; $display("FAIL zw_values: got %0d bad entries want 0", nbad); end
        total++; if (c1 != N1 || c2 != N2 || c3 != N3) begin
            bad++; $display("FAIL zw_counts: got %0d/%0d/%0d want 8/32/256", c1, c2, c3); end
        total++; if (multi_en != me0 || spurious != sp0) begin
            bad++; $display("FAIL zw_strobe_hygiene: got multi=%0d spur=%0d want 0/0", multi_en - me0, spurious - sp0); end
        total++; if (dict_err !== 1'b0) begin bad++; $display("FAIL zw_dict_err: got %0b want 0", dict_err); end
        total++; if (req_a.size() - rb != TOTAL || req_a[rb] != BASE) begin
            bad++; $display("FAIL zw_requests: got %0d want %0d", req_a.size() - rb, TOTAL); end
        vals0 = {dict1_write_val, dict2_write_val, dict3_write_val}; vc0 = valid_cyc; ob0 = obs_d.size();
        repeat (20) @(negedge clk);
        #1;
        total++; if ({dict1_write_val, dict2_write_val, dict3_write_val} !== vals0 || valid_cyc != vc0 ||
                     obs_d.size() != ob0 || done !== 1'b1) begin
            bad++; $display("FAIL zw_quiet_after_done: got vals=%0h strobes=%0d want vals=%0h strobes=0",
                            {dict1_write_val, dict2_write_val, dict3_write_val}, obs_d.size() - ob0, vals0); end
    endtask

    task automatic test_start_in_done();
        int vc0, ob0;
        vc0 = valid_cyc; ob0 = obs_d.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(negedge clk);
        #1;
        total++; if (valid_cyc != vc0 || obs_d.size() != ob0) begin
            bad++; $display("FAIL done_start_ignored: got valid=%0d strobes=%0d want 0/0", valid_cyc - vc0, obs_d.size() - ob0); end
        total++; if ({done, proc_resetn} !== 2'b11) begin
            bad++; $display("FAIL done_sticky: got %0b want 11", {done, proc_resetn}); end
    endtask

    task automatic test_stall();
        int cyc, sc, er, base, ev0, nbad, c1, c2, c3;
        bit to;
        pulse_reset();
        fill_image();
        base = obs_d.size(); ev0 = en_valid;
        run_load(9, cyc, to, sc, er);
        total++; if (sc != 4) begin bad++; $display("FAIL stall_hold: got %0d cycles want 4", sc); end
        total++; if (en_valid != ev0) begin bad++; $display("FAIL stall_no_enable: got %0d want 0", en_valid - ev0); end
        total++; if (to || cyc != 596) begin bad++; $display("FAIL stall_done_cycle: got %0d want 596", cyc); end
        total++; if (obs_d.size() <= base + 9 || obs_d[base + 9] != 2 || obs_v[base + 9] != (image[9] & width_mask(2))) begin
            bad++; $display("FAIL stall_value: got %0h want %0h", (obs_v.size() > base + 9) ? obs_v[base + 9] : 32'hX,
                            image[9] & width_mask(2)); end
        scan_stream(base, nbad, c1, c2, c3);
        total++; if (nbad != 0 || c1 != N1 || c2 != N2 || c3 != N3) begin
            bad++; $display("FAIL stall_stream: got bad=%0d counts %0d/%0d/%0d want 0 8/32/256", nbad, c1, c2, c3); end
    endtask

    task automatic test_err();
        int cyc, sc, er, base;
        bit to;
        pulse_reset();
        fill_image();
        image[0] = 32'h0000_0080;
        base = obs_d.size();
        run_load(-1, cyc, to, sc, er);
        total++; if (obs_d.size() <= base || obs_v[base] != 32'h0) begin
            bad++; $display("FAIL err_val: got %0h want 0", (obs_v.size() > base) ? obs_v[base] : 32'hX); end
        repeat (10) @(negedge clk);
        #1;
        total++; if ({dict_err, done} !== 2'b11) begin
            bad++; $display("FAIL err_sticky: got err/done=%0b want 11", {dict_err, done}); end
    endtask

    task automatic test_mid_reset();
        int cyc, sc, er, base, rb, nbad, c1, c2, c3, guard;
        bit to;
        pulse_reset();
        fill_image();
        base = obs_d.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        guard = 0;
        while (obs_d.size() < base + 100 && guard < 1000) begin @(negedge clk); guard++; end
        total++; if (obs_d.size() < base + 100) begin
            bad++; $display("FAIL mid_progress: got %0d strobes want 100", obs_d.size() - base); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        total++; if ({mem_valid, dict1_write_enable, dict2_write_enable, dict3_write_enable, proc_resetn, done, dict_err} !== 7'b0 ||
                     mem_addr !== BASE || {dict1_write_val, dict2_write_val, dict3_write_val} !== 32'h0) begin
            bad++; $display("FAIL mid_reset_values: got valid=%0b addr=%0h vals=%0h want 0 %0h 0", mem_valid, mem_addr,
                            {dict1_write_val, dict2_write_val, dict3_write_val}, BASE); end
        @(negedge clk); reset = 1'b0;
        base = obs_d.size(); rb = req_a.size();
        run_load(-1, cyc, to, sc, er);
        total++; if (req_a.size() <= rb || req_a[rb] != BASE) begin
            bad++; $display("FAIL mid_first_req: got %0h want %0h", (req_a.size() > rb) ? req_a[rb] : 32'hX, BASE); end
        scan_stream(base, nbad, c1, c2, c3);
        total++; if (to || nbad != 0 || c1 != N1 || c2 != N2 || c3 != N3) begin
            bad++; $display("FAIL mid_reload: got bad=%0d counts %0d/%0d/%0d want 0 8/32/256", nbad, c1, c2, c3); end
    endtask

    task automatic test_start_through_reset();
        int guard;
        @(negedge clk); reset = 1'b1; start = 1'b1;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        #1;
        total++; if (mem_valid !== 1'b1 || mem_addr !== BASE) begin
            bad++; $display("FAIL held_start: got valid=%0b addr=%0h want 1 %0h", mem_valid, mem_addr, BASE); end
        start = 1'b0;
        guard = 0;
        while (!done && guard < 2000) begin @(negedge clk); guard++; end
        total++; if (done !== 1'b1) begin bad++; $display("FAIL held_start_done: got %0b want 1", done); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_start_in_done();
        test_stall();
        test_err();
        test_mid_reset();
        test_start_through_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
